// File: rtl/clk_ctrl_pkg.sv
// Shared constants and state encoding for the CPU step-clock controller.
package clk_ctrl_pkg;
    localparam int DIV_DEFAULT      = 4;
    localparam int DEBOUNCE_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        STEP = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;
endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer, debouncer and rising-level detector.
module btn_debounce
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic btn,
    output logic btn_level,
    output logic step_req
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          btn_s1, btn_s2, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_level <= 1'b0;
            level_d   <= 1'b0;
            cnt       <= '0;
        end else begin
            btn_s1  <= btn;
            btn_s2  <= btn_s1;
            level_d <= btn_level;
            // Any sample that agrees with the accepted level restarts the count.
            if (btn_s2 != btn_level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level <= btn_s2;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign step_req = btn_level & ~level_d;
endmodule

// File: rtl/step_clock_ctrl.sv
// CPU clock-enable generator: divided free-run ticks or one tick per button press.
module step_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV             = DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 32
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             mode,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_tick,
    output logic             btn_level,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int DW = $clog2(DIV);

    logic          mode_s1, mode_s2;
    logic          step_req;
    state_t        state;
    logic [DW-1:0] div_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .sysclk    (sysclk),
        .reset     (reset),
        .btn       (step_btn),
        .btn_level (btn_level),
        .step_req  (step_req)
    );

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            mode_s1     <= 1'b0;
            mode_s2     <= 1'b0;
            state       <= STEP;
            div_cnt     <= '0;
            cpu_tick    <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            cycle_count <= '0;
        end else begin
            mode_s1 <= mode;
            mode_s2 <= mode_s1;
            // Halt wins over mode changes and over any tick due this cycle.
            if (state == HALT || halt) begin
                state    <= HALT;
                cpu_tick <= 1'b0;
                running  <= 1'b0;
                halted   <= 1'b1;
            end else if (state == STEP) begin
                cpu_tick    <= step_req;
                cycle_count <= cycle_count + {{(CNT_W-1){1'b0}}, step_req};
                if (mode_s2) begin
                    state   <= RUN;
                    running <= 1'b1;
                    div_cnt <= '0;
                end
            end else if (!mode_s2) begin
                state    <= STEP;
                running  <= 1'b0;
                div_cnt  <= '0;
                cpu_tick <= 1'b0;
            end else if (div_cnt == DW'(DIV - 1)) begin
                cpu_tick    <= 1'b1;
                div_cnt     <= '0;
                cycle_count <= cycle_count + 1'b1;
            end else begin
                cpu_tick <= 1'b0;
                div_cnt  <= div_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_step_clock_ctrl.sv
// Self-checking bench for step_clock_ctrl: directed table, corner sequences, random vs model.
module tb_step_clock_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 4;
    localparam int CW  = 4;

    logic          sysclk = 1'b0, reset = 1'b0, mode = 1'b0, step_btn = 1'b0, halt = 1'b0;
    logic          cpu_tick, btn_level, running, halted;
    logic [CW-1:0] cycle_count;

    step_clock_ctrl #(.DIV(DIV), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .mode        (mode),
        .step_btn    (step_btn),
        .halt        (halt),
        .cpu_tick    (cpu_tick),
        .btn_level   (btn_level),
        .running     (running),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int passed = 0;

    // Behavioural model: sample histories, run-length debounce, edges-since-RUN-entry.
    int m_b1, m_b2, m_m1, m_m2, m_level, m_level_prev, m_run;
    int m_st;  // 0 step, 1 run, 2 halted
    int m_n, m_tick, m_count;

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_m1 = 0; m_m2 = 0; m_level = 0; m_level_prev = 0;
        m_run = 0; m_st = 0; m_n = 0; m_tick = 0; m_count = 0;
    endtask

    task automatic model_step(input int btn_in, input int mode_in, input int halt_in);
        int req, o_b2, o_m2;
        o_b2 = m_b2;
        o_m2 = m_m2;
        req = (m_level == 1 && m_level_prev == 0) ? 1 : 0;
        m_level_prev = m_level;
        if (o_b2 != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = o_b2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_b2 = m_b1; m_b1 = btn_in;
        m_m2 = m_m1; m_m1 = mode_in;
        if (m_st == 2 || halt_in != 0) begin
            m_st = 2; m_tick = 0;
        end else if (m_st == 0) begin
            m_tick = req;
            if (o_m2 != 0) begin m_st = 1; m_n = 0; end
        end else if (o_m2 == 0) begin
            m_st = 0; m_tick = 0;
        end else begin
            m_n++;
            m_tick = (m_n % DIV == 0) ? 1 : 0;
        end
        m_count = (m_count + m_tick) % (1 << CW);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    endtask

    task automatic check_all();
        chk("cpu_tick", int'(cpu_tick), m_tick);
        chk("btn_level", int'(btn_level), m_level);
        chk("running", int'(running), (m_st == 1) ? 1 : 0);
        chk("halted", int'(halted), (m_st == 2) ? 1 : 0);
        chk("cycle_count", int'(cycle_count), m_count);
    endtask

    // One clock edge; inputs are changed only at edge+1.
    task automatic cyc();
        @(posedge sysclk);
        if (reset) model_reset();
        else model_step(int'(step_btn), int'(mode), int'(halt));
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_tick", int'(cpu_tick), 0);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_count", int'(cycle_count), 0);
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic btn;
        logic e_tick;
        logic e_level;
        int   e_count;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int ticks, first, last_cnt, saved, hold, found;
        logic wrapped;

        for (int i = 0; i < 10; i++) begin
            tbl[i].btn     = 1'b1;
            tbl[i].e_level = (i >= DEB + 1);
            tbl[i].e_tick  = (i == DEB + 2);
            tbl[i].e_count = (i >= DEB + 2) ? 1 : 0;
        end

        #1;
        do_reset();

        // Single-step latency: row i is checked right after edge i.
        step_btn = 1'b1;
        foreach (tbl[i]) begin
            step_btn = tbl[i].btn;
            cyc();
            chk($sformatf("tbl%0d_tick", i), int'(cpu_tick), int'(tbl[i].e_tick));
            chk($sformatf("tbl%0d_level", i), int'(btn_level), int'(tbl[i].e_level));
            chk($sformatf("tbl%0d_count", i), int'(cycle_count), tbl[i].e_count);
        end
        repeat (10) cyc();
        chk("held_count", int'(cycle_count), 1);
        step_btn = 1'b0;
        repeat (10) cyc();
        chk("release_no_tick_count", int'(cycle_count), 1);

        // Short bounces never reach the debounce threshold.
        do_reset();
        ticks = 0;
        repeat (5) begin
            step_btn = 1'b1;
            repeat (3) begin cyc(); ticks += int'(cpu_tick); end
            step_btn = 1'b0;
            repeat (3) begin cyc(); ticks += int'(cpu_tick); end
        end
        chk("bounce_ticks", ticks, 0);
        chk("bounce_level", int'(btn_level), 0);
        chk("bounce_count", int'(cycle_count), 0);

        // RUN mode: entry after the mode synchronizer, first tick DIV edges later.
        do_reset();
        mode = 1'b1;
        ticks = 0; first = -1;
        for (int e = 0; e < 40; e++) begin
            cyc();
            if (cpu_tick) begin
                ticks++;
                if (first < 0) first = e;
            end
        end
        chk("run_first_tick_edge", first, 2 + DIV);
        chk("run_ticks", ticks, 9);
        chk("run_count", int'(cycle_count), 9);
        chk("run_running", int'(running), 1);

        // Halt landing on a tick cycle suppresses it and freezes everything.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if ((m_n + 1) % DIV == 0) found = 1;
            else cyc();
        end
        chk("halt_align", found, 1);
        saved = int'(cycle_count);
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        chk("halt_no_tick", int'(cpu_tick), 0);
        chk("halt_flag", int'(halted), 1);
        chk("halt_count", int'(cycle_count), saved);
        ticks = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 10 == 0) mode = ~mode;
            step_btn = (k % 16) < 8;
            cyc();
            ticks += int'(cpu_tick);
        end
        chk("halt_ticks_after", ticks, 0);
        chk("halt_count_frozen", int'(cycle_count), saved);
        chk("halt_still", int'(halted), 1);

        // Reset mid-RUN with the button held: button re-debounces from zero.
        step_btn = 1'b0; mode = 1'b0;
        do_reset();
        mode = 1'b1; step_btn = 1'b1;
        repeat (20) cyc();
        mode = 1'b0;
        do_reset();
        first = -1;
        for (int e = 0; e < 30 && first < 0; e++) begin
            cyc();
            if (cpu_tick) first = e;
        end
        chk("post_reset_tick_edge", first, DEB + 2);
        repeat (5) cyc();
        chk("post_reset_count", int'(cycle_count), 1);

        // Counter wrap after 34 ticks with a 4-bit count.
        step_btn = 1'b0;
        do_reset();
        mode = 1'b1;
        ticks = 0; wrapped = 1'b0; last_cnt = 0;
        for (int e = 0; e < 34 * DIV + 20 && ticks < 34; e++) begin
            cyc();
            if (cpu_tick) ticks++;
            if (last_cnt == 15 && int'(cycle_count) == 0) wrapped = 1'b1;
            last_cnt = int'(cycle_count);
        end
        chk("wrap_ticks", ticks, 34);
        chk("wrap_seen", int'(wrapped), 1);
        chk("wrap_count", int'(cycle_count), 2);

        // Random traffic against the model.
        mode = 1'b0;
        do_reset();
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                step_btn = 1'($urandom_range(1, 0));
                hold = int'($urandom_range(10, 1));
            end
            hold--;
            if ($urandom_range(59, 0) == 0) mode = ~mode;
            halt = ($urandom_range(799, 0) == 0);
            if ($urandom_range(299, 0) == 0) begin
                halt = 1'b0;
                do_reset();
            end else begin
                cyc();
            end
        end
        halt = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
